wash_phase_timer: RTL and testbench
===================================

# wash_phase_timer

Phase-duration timer that drives the `timer_*` done inputs of the `washing_machine` controller. It watches the controller's one-hot phase outputs and loads a per-phase duration whenever a new phase is entered. It counts the duration down in prescaled one-second ticks and raises the matching `timer_*` line when the phase has run its time. It sits directly upstream of the controller, in a closed loop with it.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per timer tick; must be ≥1.
- `CNT_W`, default 16: width of the countdown counter and `remaining`.
- `T_SOAK_LOW`, default 600: soak_low duration, in ticks.
- `T_SOAK_HIGH`, default 1200: soak_high duration, in ticks.
- `T_WASH_LOW`, default 900: wash_low duration, in ticks.
- `T_WASH_HIGH`, default 1800: wash_high duration, in ticks.
- `T_RINSE`, default 600: rinse duration, in ticks.
- `T_SPIN`, default 300: spin duration, in ticks.
- `T_DRAIN`, default 120: drain duration, in ticks.

- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `pause`  in  1  freezes the countdown and the prescaler (door open or user hold).
- `idle`, `soak_low`, `soak_high`, `wash_low`, `wash_high`, `rinse`, `spin`, `drain`  in  1 each  phase indicators from the controller.
- `timer_soak_low`, `timer_soak_high`, `timer_wash_low`, `timer_wash_high`, `timer_rinse`, `timer_spin`, `timer_drain`  out  1 each  phase-elapsed flags, one per phase.
- `remaining`  out  CNT_W  ticks left in the current phase.
- `phase_err`  out  1  more than one phase input is high.

## Operation
- **Phase decode.** The eight phase inputs decode to a 3-bit phase code.
  - All inputs low, or only `idle` high, decodes to IDLE.
  - Two or more inputs high is invalid.
- **Invalid input.** When the decode is invalid:
  - `phase_err` = 1 in the same cycle.
  - Counter, prescaler, `phase_q` and `done` hold their values.
  - All `timer_*` outputs are forced to 0.
- **Phase entry.** When the decode is valid and differs from the registered `phase_q`, the next edge does all of the following:
  - `phase_q` takes the new phase.
  - The counter loads the duration for that phase (0 for IDLE).
  - The prescaler clears to 0.
  - `done` clears, except that a loaded duration of 0 on a non-IDLE phase sets `done` immediately.
- **Counting.** Counting is active when the phase is valid, `phase_q` is not IDLE, `pause` = 0 and `done` = 0.
  - While counting, the prescaler counts from 0 to TICK_DIV−1 and then wraps.
  - On the wrap edge the counter decrements by 1.
  - The edge on which the counter reaches 0 also sets `done`.
- **Done flag.** `done` is sticky until the phase changes or `rst` is asserted.
- **Outputs.**
  - `timer_X` = `done` & (`phase_q` == X) & !`phase_err`, which is registered state plus decode logic.
  - `remaining` = counter value.
- **Same phase held.** A phase that stays continuously active never reloads. Re-entering a phase through any other phase does reload.
- **IDLE.** The counter is held at 0 and all `timer_*` outputs are 0.
- **Durations.** Each duration must be < 2^CNT_W. Exceeding this is an elaboration error (generate-time assertion). Counter arithmetic is unsigned and never decrements below 0.

## Timing
- **Reset.** Values after reset:
  - `phase_q` = IDLE.
  - Counter = 0, prescaler = 0, `done` = 0.
  - All `timer_*` = 0, `remaining` = 0, `phase_err` = 0.
- **Reset mid-phase.** `rst` asserted mid-phase returns the block to the reset state on the next edge. The phase is then re-entered, and reloaded, on the first edge after `rst` deasserts.
- **Latency.** A phase with duration T ≥ 1 loads at edge k. With no pause, `timer_X` rises at edge k + T·TICK_DIV.
- **Pause.** Each cycle with `pause` high delays the `timer_X` rise by one cycle. The partial tick held in the prescaler is preserved across the pause.
- **Pause with phase change.** When `pause` and a phase change occur in the same cycle, the load wins and counting starts frozen.
- **Phase change on the done edge.** When a phase change coincides with the edge that would set `done`, the load wins and no `timer_*` output pulses.
- **Phase error.** `phase_err` is combinational from the inputs, so it follows them with 0 cycles of latency.

## Structure
- **Shared package `wm_pkg`**, which holds:
  - `phase_e`, a 3-bit enum: PH_IDLE, PH_SOAK_LOW, PH_SOAK_HIGH, PH_WASH_LOW, PH_WASH_HIGH, PH_RINSE, PH_SPIN, PH_DRAIN. The controller shares this encoding.
  - The default duration constants.
- **Sub-module `tick_prescaler`**:
  - Parameter TICK_DIV; inputs `clk`, `rst`, `en`, `clr`; output `tick`.
  - `tick` = 1 on the cycle the count is TICK_DIV−1 and `en` = 1.
  - With TICK_DIV = 1, `tick` = `en`.
- **Top `wash_phase_timer`** contains the decoder, the phase register, the duration mux, the counter and the `done` flag.

## Test plan
All scenarios use TICK_DIV=4, T_SOAK_HIGH=3, T_WASH_HIGH=2, T_DRAIN=1, T_SPIN=0, CNT_W=8.
- **Nominal countdown.** Raise `soak_high` at edge 0 → `remaining` = 3 after edge 1 and steps 3→2→1→0 every 4 cycles. `timer_soak_high` rises at edge 13 and stays high while `soak_high` is held.
- **Phase handover.** Switch `soak_high`→`wash_high` with `timer_soak_high`=1 → `timer_soak_high` drops on the next edge, `remaining` = 2, and `timer_wash_high` rises 8 cycles after the load.
- **Pause.** Assert `pause` for 5 cycles, starting 2 cycles into a tick during `wash_high` → the `timer_wash_high` rise is delayed by exactly 5 cycles and `remaining` is frozen throughout the pause.
- **Phase error.** Drive `rinse` and `spin` high together for 3 cycles → `phase_err` = 1 and all `timer_*` = 0 during those cycles. After `spin` drops, counting resumes from the held `remaining`.
- **Zero duration.** Raise `spin` with T_SPIN=0 → `timer_spin` = 1 at the load edge with `remaining` = 0.
- **Reset mid-phase.** Pulse `rst` during `drain` with `remaining`=1 → all outputs are 0 on the next edge. After release, `drain` reloads and `timer_drain` rises 4 cycles after the reload.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the washing machine controller and its phase timer.
// phase_e is the one phase encoding both blocks agree on; the DEF_*
// constants are the production phase durations in one-second ticks.
package wm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_SOAK_LOW  = 3'd1,
    PH_SOAK_HIGH = 3'd2,
    PH_WASH_LOW  = 3'd3,
    PH_WASH_HIGH = 3'd4,
    PH_RINSE     = 3'd5,
    PH_SPIN      = 3'd6,
    PH_DRAIN     = 3'd7
  } phase_e;

  localparam int DEF_TICK_DIV    = 50_000_000;
  localparam int DEF_T_SOAK_LOW  = 600;
  localparam int DEF_T_SOAK_HIGH = 1200;
  localparam int DEF_T_WASH_LOW  = 900;
  localparam int DEF_T_WASH_HIGH = 1800;
  localparam int DEF_T_RINSE     = 600;
  localparam int DEF_T_SPIN      = 300;
  localparam int DEF_T_DRAIN     = 120;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the timer tick rate.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the count
//   en   - advance the count this cycle; when low the partial tick is held
//   clr  - restart the count at 0 (takes priority over en)
//   tick - high for the one enabled cycle in which the count is TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A divide-by-1 still needs a one-bit register; it just never leaves 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en && (cnt_q == PW'(TICK_DIV - 1));

  // Wrap on the tick cycle so the next tick is exactly TICK_DIV enabled
  // cycles later; a disabled cycle simply keeps the partial count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase-duration timer feeding the timer_* done inputs of washing_machine.
// It decodes the controller's one-hot phase outputs, loads the duration of
// each newly entered phase, counts it down in prescaled ticks and raises the
// matching timer_* flag once the phase has run its time.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   pause                 - freezes countdown and prescaler
//   idle .. drain         - phase indicators from the controller
//   timer_soak_low .. timer_drain - per-phase elapsed flags
//   remaining             - ticks left in the current phase
//   phase_err             - more than one phase indicator is high
module wash_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int CNT_W       = 16,
  parameter int T_SOAK_LOW  = DEF_T_SOAK_LOW,
  parameter int T_SOAK_HIGH = DEF_T_SOAK_HIGH,
  parameter int T_WASH_LOW  = DEF_T_WASH_LOW,
  parameter int T_WASH_HIGH = DEF_T_WASH_HIGH,
  parameter int T_RINSE     = DEF_T_RINSE,
  parameter int T_SPIN      = DEF_T_SPIN,
  parameter int T_DRAIN     = DEF_T_DRAIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             idle,
  input  logic             soak_low,
  input  logic             soak_high,
  input  logic             wash_low,
  input  logic             wash_high,
  input  logic             rinse,
  input  logic             spin,
  input  logic             drain,
  output logic             timer_soak_low,
  output logic             timer_soak_high,
  output logic             timer_wash_low,
  output logic             timer_wash_high,
  output logic             timer_rinse,
  output logic             timer_spin,
  output logic             timer_drain,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_err
);

  localparam longint DUR_LIMIT = longint'(1) << CNT_W;

  if (TICK_DIV < 1) begin : g_bad_div
    $error("wash_phase_timer: TICK_DIV must be at least 1");
  end

  if (T_SOAK_LOW >= DUR_LIMIT || T_SOAK_HIGH >= DUR_LIMIT ||
      T_WASH_LOW >= DUR_LIMIT || T_WASH_HIGH >= DUR_LIMIT ||
      T_RINSE >= DUR_LIMIT || T_SPIN >= DUR_LIMIT || T_DRAIN >= DUR_LIMIT) begin : g_bad_dur
    $error("wash_phase_timer: a phase duration does not fit in CNT_W bits");
  end

  function automatic logic [CNT_W-1:0] phaseDuration(input phase_e ph);
    logic [CNT_W-1:0] dur;
    dur = '0;
    case (ph)
      PH_SOAK_LOW:  dur = CNT_W'(T_SOAK_LOW);
      PH_SOAK_HIGH: dur = CNT_W'(T_SOAK_HIGH);
      PH_WASH_LOW:  dur = CNT_W'(T_WASH_LOW);
      PH_WASH_HIGH: dur = CNT_W'(T_WASH_HIGH);
      PH_RINSE:     dur = CNT_W'(T_RINSE);
      PH_SPIN:      dur = CNT_W'(T_SPIN);
      PH_DRAIN:     dur = CNT_W'(T_DRAIN);
      default:      dur = '0;
    endcase
    return dur;
  endfunction

  logic [7:0]       phaseIn;
  logic [3:0]       nHigh;
  phase_e           phaseDec;
  logic             decValid;
  logic             load;
  logic             counting;
  logic             tick;
  logic [CNT_W-1:0] loadDur;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Bit index of each indicator equals its phase_e code, so the position of
  // the single high bit is the phase. idle alone and nothing-high both land
  // on PH_IDLE.
  assign phaseIn = {drain, spin, rinse, wash_high, wash_low, soak_high, soak_low, idle};

  always_comb begin
    nHigh    = '0;
    phaseDec = PH_IDLE;
    for (int i = 0; i < 8; i++) begin
      nHigh = nHigh + {3'b000, phaseIn[i]};
    end
    for (int i = 1; i < 8; i++) begin
      if (phaseIn[i]) begin
        phaseDec = phase_e'(3'(i));
      end
    end
  end

  assign decValid  = (nHigh < 4'd2);
  assign phase_err = !decValid;
  assign load      = decValid && (phaseDec != phase_q);
  assign counting  = decValid && (phase_q != PH_IDLE) && !pause && !done_q;
  assign loadDur   = phaseDuration(phaseDec);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (counting),
    .clr (load),
    .tick(tick)
  );

  // A phase change always wins over a tick on the same edge, so a phase left
  // right as its time runs out never flashes its timer_* flag. A zero-length
  // working phase is complete the moment it is entered.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (load) begin
      phase_d = phaseDec;
      cnt_d   = loadDur;
      done_d  = (phaseDec != PH_IDLE) && (loadDur == '0);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign remaining       = cnt_q;
  assign timer_soak_low  = done_q && (phase_q == PH_SOAK_LOW)  && !phase_err;
  assign timer_soak_high = done_q && (phase_q == PH_SOAK_HIGH) && !phase_err;
  assign timer_wash_low  = done_q && (phase_q == PH_WASH_LOW)  && !phase_err;
  assign timer_wash_high = done_q && (phase_q == PH_WASH_HIGH) && !phase_err;
  assign timer_rinse     = done_q && (phase_q == PH_RINSE)     && !phase_err;
  assign timer_spin      = done_q && (phase_q == PH_SPIN)      && !phase_err;
  assign timer_drain     = done_q && (phase_q == PH_DRAIN)     && !phase_err;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed testbench for wash_phase_timer with a small tick divider and
// short phase durations so every timing corner is reachable in a few cycles.
module tb_wash_phase_timer;

  localparam int CNT_W = 8;

  // Phase input patterns, bit order {drain,spin,rinse,wash_high,wash_low,soak_high,soak_low,idle}
  localparam logic [7:0] PI_NONE = 8'h00;
  localparam logic [7:0] PI_ID   = 8'h01;
  localparam logic [7:0] PI_SH   = 8'h04;
  localparam logic [7:0] PI_WH   = 8'h10;
  localparam logic [7:0] PI_RI   = 8'h20;
  localparam logic [7:0] PI_SP   = 8'h40;
  localparam logic [7:0] PI_DR   = 8'h80;

  // Timer flag patterns, bit order {drain,spin,rinse,wash_high,wash_low,soak_high,soak_low}
  localparam logic [6:0] TF_NONE = 7'h00;
  localparam logic [6:0] TF_SH   = 7'h02;
  localparam logic [6:0] TF_WH   = 7'h08;
  localparam logic [6:0] TF_RI   = 7'h10;
  localparam logic [6:0] TF_SP   = 7'h20;
  localparam logic [6:0] TF_DR   = 7'h40;

  typedef struct {
    string            name;
    logic [7:0]       ph;
    logic             pause;
    logic             rst;
    logic [6:0]       expTimer;
    logic [CNT_W-1:0] expRem;
    logic             expErr;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             pause;
  logic [7:0]       phaseIn;
  logic [6:0]       timerVec;
  logic [CNT_W-1:0] remaining;
  logic             phase_err;
  logic             timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high;
  logic             timer_rinse, timer_spin, timer_drain;

  int numChecks;
  int numPassed;
  vec_t vecs[$];

  wash_phase_timer #(
    .TICK_DIV   (4),
    .CNT_W      (CNT_W),
    .T_SOAK_LOW (5),
    .T_SOAK_HIGH(3),
    .T_WASH_LOW (6),
    .T_WASH_HIGH(2),
    .T_RINSE    (5),
    .T_SPIN     (0),
    .T_DRAIN    (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pause          (pause),
    .idle           (phaseIn[0]),
    .soak_low       (phaseIn[1]),
    .soak_high      (phaseIn[2]),
    .wash_low       (phaseIn[3]),
    .wash_high      (phaseIn[4]),
    .rinse          (phaseIn[5]),
    .spin           (phaseIn[6]),
    .drain          (phaseIn[7]),
    .timer_soak_low (timer_soak_low),
    .timer_soak_high(timer_soak_high),
    .timer_wash_low (timer_wash_low),
    .timer_wash_high(timer_wash_high),
    .timer_rinse    (timer_rinse),
    .timer_spin     (timer_spin),
    .timer_drain    (timer_drain),
    .remaining      (remaining),
    .phase_err      (phase_err)
  );

  assign timerVec = {timer_drain, timer_spin, timer_rinse, timer_wash_high,
                     timer_wash_low, timer_soak_high, timer_soak_low};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input string name, input logic [7:0] ph, input logic pz,
                                 input logic rs, input logic [6:0] expTimer,
                                 input logic [CNT_W-1:0] expRem, input logic expErr);
    vec_t v;
    v.name     = name;
    v.ph       = ph;
    v.pause    = pz;
    v.rst      = rs;
    v.expTimer = expTimer;
    v.expRem   = expRem;
    v.expErr   = expErr;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs, let one rising edge pass, then settle 1 time unit.
  task automatic applyStimulus(input logic [7:0] ph, input logic pz, input logic rs);
    phaseIn = ph;
    pause   = pz;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expTimer,
                             input logic [CNT_W-1:0] expRem, input logic expErr);
    numChecks++;
    if (timerVec === expTimer && remaining === expRem && phase_err === expErr) begin
      numPassed++;
    end else begin
      $display("[TB] FAIL %s: got timer=%b rem=%0d err=%b, expected timer=%b rem=%0d err=%b",
               name, timerVec, remaining, phase_err, expTimer, expRem, expErr);
    end
  endtask

  task automatic runStep(input string name, input logic [7:0] ph, input logic pz,
                         input logic rs, input logic [6:0] expTimer,
                         input logic [CNT_W-1:0] expRem, input logic expErr);
    applyStimulus(ph, pz, rs);
    checkOutput(name, expTimer, expRem, expErr);
  endtask

  initial begin
    numChecks = 0;
    numPassed = 0;
    phaseIn   = PI_NONE;
    pause     = 1'b0;
    rst       = 1'b1;

    // Reset and idle decoding.
    addVec("reset0", PI_NONE, 0, 1, TF_NONE, 0, 0);
    addVec("reset1", PI_NONE, 0, 1, TF_NONE, 0, 0);
    addVec("idle_none", PI_NONE, 0, 0, TF_NONE, 0, 0);
    addVec("idle_only", PI_ID, 0, 0, TF_NONE, 0, 0);

    // Nominal countdown: soak_high T=3, one decrement every 4 edges.
    addVec("sh_load", PI_SH, 0, 0, TF_NONE, 3, 0);
    for (int i = 1; i <= 11; i++) begin
      addVec($sformatf("sh_cnt%0d", i), PI_SH, 0, 0, TF_NONE,
             (i < 4) ? 8'd3 : (i < 8) ? 8'd2 : 8'd1, 0);
    end
    addVec("sh_done", PI_SH, 0, 0, TF_SH, 0, 0);
    addVec("sh_hold1", PI_SH, 0, 0, TF_SH, 0, 0);
    addVec("sh_hold2", PI_SH, 0, 0, TF_SH, 0, 0);

    // Handover to wash_high T=2: timer rises 8 edges after the load.
    addVec("wh_load", PI_WH, 0, 0, TF_NONE, 2, 0);
    for (int i = 1; i <= 7; i++) begin
      addVec($sformatf("wh_cnt%0d", i), PI_WH, 0, 0, TF_NONE, (i < 4) ? 8'd2 : 8'd1, 0);
    end
    addVec("wh_done", PI_WH, 0, 0, TF_WH, 0, 0);
    addVec("wh_hold", PI_WH, 0, 0, TF_WH, 0, 0);

    // Rinse T=5 with a 3-cycle rinse+spin conflict two cycles into a tick.
    addVec("ri_load", PI_RI, 0, 0, TF_NONE, 5, 0);
    addVec("ri_cnt1", PI_RI, 0, 0, TF_NONE, 5, 0);
    addVec("ri_cnt2", PI_RI, 0, 0, TF_NONE, 5, 0);
    for (int i = 0; i < 3; i++) begin
      addVec($sformatf("ri_err%0d", i), PI_RI | PI_SP, 0, 0, TF_NONE, 5, 1);
    end
    addVec("ri_resume1", PI_RI, 0, 0, TF_NONE, 5, 0);
    addVec("ri_resume2", PI_RI, 0, 0, TF_NONE, 4, 0);

    // Zero-length spin completes on its load edge; a conflict masks the flag.
    addVec("sp_load", PI_SP, 0, 0, TF_SP, 0, 0);
    addVec("sp_err", PI_SP | PI_DR, 0, 0, TF_NONE, 0, 1);
    addVec("sp_back", PI_SP, 0, 0, TF_SP, 0, 0);
    addVec("to_idle", PI_ID, 0, 0, TF_NONE, 0, 0);

    foreach (vecs[i]) begin
      runStep(vecs[i].name, vecs[i].ph, vecs[i].pause, vecs[i].rst,
              vecs[i].expTimer, vecs[i].expRem, vecs[i].expErr);
    end

    // Pause: five frozen cycles starting two cycles into a tick push the
    // wash_high completion from load+8 to load+13.
    runStep("pz_load", PI_WH, 0, 0, TF_NONE, 2, 0);
    runStep("pz_run1", PI_WH, 0, 0, TF_NONE, 2, 0);
    runStep("pz_run2", PI_WH, 0, 0, TF_NONE, 2, 0);
    for (int i = 0; i < 5; i++) begin
      runStep($sformatf("pz_hold%0d", i), PI_WH, 1, 0, TF_NONE, 2, 0);
    end
    runStep("pz_run3", PI_WH, 0, 0, TF_NONE, 2, 0);
    runStep("pz_tick1", PI_WH, 0, 0, TF_NONE, 1, 0);
    for (int i = 0; i < 3; i++) begin
      runStep($sformatf("pz_wait%0d", i), PI_WH, 0, 0, TF_NONE, 1, 0);
    end
    runStep("pz_done", PI_WH, 0, 0, TF_WH, 0, 0);

    // Pause together with a phase change: the load happens, counting stays frozen.
    runStep("pzl_load", PI_SH, 1, 0, TF_NONE, 3, 0);
    for (int i = 0; i < 4; i++) begin
      runStep($sformatf("pzl_frozen%0d", i), PI_SH, 1, 0, TF_NONE, 3, 0);
    end
    for (int i = 0; i < 3; i++) begin
      runStep($sformatf("pzl_run%0d", i), PI_SH, 0, 0, TF_NONE, 3, 0);
    end
    runStep("pzl_tick", PI_SH, 0, 0, TF_NONE, 2, 0);

    // Reset mid-drain, then drain reloads and completes 4 edges later.
    runStep("dr_load", PI_DR, 0, 0, TF_NONE, 1, 0);
    runStep("dr_cnt1", PI_DR, 0, 0, TF_NONE, 1, 0);
    runStep("dr_rst", PI_DR, 0, 1, TF_NONE, 0, 0);
    runStep("dr_reload", PI_DR, 0, 0, TF_NONE, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      runStep($sformatf("dr_cnt_after%0d", i), PI_DR, 0, 0, TF_NONE, 1, 0);
    end
    runStep("dr_done", PI_DR, 0, 0, TF_DR, 0, 0);

    // Phase change on the edge that would complete drain: load wins, no pulse.
    runStep("ch_idle", PI_ID, 0, 0, TF_NONE, 0, 0);
    runStep("ch_load", PI_DR, 0, 0, TF_NONE, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      runStep($sformatf("ch_cnt%0d", i), PI_DR, 0, 0, TF_NONE, 1, 0);
    end
    runStep("ch_switch", PI_WH, 0, 0, TF_NONE, 2, 0);
    runStep("ch_after", PI_WH, 0, 0, TF_NONE, 2, 0);

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
